// File: rtl/piso_tx_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter and its
// matching SIPO receiver: FSM state encoding, bit-order selectors and a
// counter-width helper.
package piso_tx_pkg;

  // Two-state link FSM; the encoding is shared with the receiver side.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-order selector values for the MSB_FIRST parameter.
  localparam int BIT_ORDER_LSB_FIRST = 0;
  localparam int BIT_ORDER_MSB_FIRST = 1;

  // Width of a counter that indexes 0..w-1, never narrower than one bit.
  function automatic int cntWidth(input int w);
    int cw;
    cw = $clog2(w);
    if (cw < 1) cw = 1;
    return cw;
  endfunction

endpackage

// File: rtl/piso_tx_bit_tick_gen.sv
// Bit-period divider: counts clk cycles while enabled and pulses tick on the
// last cycle of each bit period. With one clock per bit the tick is constant.
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_BIT - 1);

  logic [7:0] div_cnt_q;
  logic [7:0] div_cnt_d;

  // A new word restarts the period; the counter wraps on each tick so it can
  // never run past the last cycle of a bit.
  assign tick = (CLKS_PER_BIT == 1) ? 1'b1 : (div_cnt_q == DIV_LAST);

  // Next divider count: clear on reload, advance or wrap while shifting.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr) begin
      div_cnt_d = 8'd0;
    end else if (en) begin
      div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
    end
  end

  // Divider register, cleared asynchronously so an abort restarts cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= 8'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter. Accepts a word on a valid/ready
// handshake and shifts it out one bit per bit period on sout, with frame
// markers on the first and last bit. A word offered on the final tick of the
// previous word is taken without an idle gap.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_first,
  output logic             frame_last,
  output logic             busy
);

  localparam int              CNT_W    = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit              SEND_MSB = (MSB_FIRST == BIT_ORDER_MSB_FIRST);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] bit_cnt_d;

  logic sout_q;
  logic sout_valid_q;
  logic frame_first_q;
  logic frame_last_q;

  logic tick;
  logic accept;
  logic shifting;
  logic next_bit;

  assign shifting = (state_q == ST_SHIFT);

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (shifting),
    .clr  (accept),
    .tick (tick)
  );

  // Ready while idle, or exactly on the closing tick of the last bit so the
  // next word follows with no gap.
  assign load_ready = (state_q == ST_IDLE) || (frame_last_q && tick);
  assign accept     = load_valid && load_ready;

  // Next FSM state, shift register and bit index.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d   = load_data;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          shreg_d   = load_data;
          bit_cnt_d = '0;
        end else if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            if (SEND_MSB) begin
              shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
              shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            end
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        shreg_d   = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Bit that will be on the line after this edge.
  assign next_bit = SEND_MSB ? shreg_d[WIDTH-1] : shreg_d[0];

  // FSM, datapath and registered line outputs; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_first_q <= 1'b0;
      frame_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      sout_q        <= (state_d == ST_SHIFT) && next_bit;
      sout_valid_q  <= (state_d == ST_SHIFT);
      frame_first_q <= (state_d == ST_SHIFT) && (bit_cnt_d == '0);
      frame_last_q  <= (state_d == ST_SHIFT) && (bit_cnt_d == LAST_BIT);
    end
  end

  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_first = frame_first_q;
  assign frame_last  = frame_last_q;
  assign busy        = shifting;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: three instances cover LSB-first, MSB-first and
// a four-clock bit period, sharing clock and reset.
module tb_piso_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] loadData;
  logic       validL, validM, validS;

  logic readyL, soutL, soutValidL, firstL, lastL, busyL;
  logic readyM, soutM, soutValidM, firstM, lastM, busyM;
  logic readyS, soutS, soutValidS, firstS, lastS, busyS;

  int totalChecks;
  int badChecks;

  logic [7:0] word;

  piso_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(0)) dutLsb (
    .clk(clk), .rst_n(rst_n), .load_valid(validL), .load_ready(readyL),
    .load_data(loadData), .sout(soutL), .sout_valid(soutValidL),
    .frame_first(firstL), .frame_last(lastL), .busy(busyL)
  );

  piso_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1)) dutMsb (
    .clk(clk), .rst_n(rst_n), .load_valid(validM), .load_ready(readyM),
    .load_data(loadData), .sout(soutM), .sout_valid(soutValidM),
    .frame_first(firstM), .frame_last(lastM), .busy(busyM)
  );

  piso_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(0)) dutSlow (
    .clk(clk), .rst_n(rst_n), .load_valid(validS), .load_ready(readyS),
    .load_data(loadData), .sout(soutS), .sout_valid(soutValidS),
    .frame_first(firstS), .frame_last(lastS), .busy(busyS)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive all inputs on the falling edge, away from the active edge.
  task automatic applyStimulus(input logic vL, input logic vM, input logic vS,
                               input logic [7:0] d);
    @(negedge clk);
    validL   = vL;
    validM   = vM;
    validS   = vS;
    loadData = d;
  endtask

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Main directed sequence.
  initial begin
    totalChecks = 0;
    badChecks   = 0;
    rst_n    = 1'b1;
    validL   = 1'b0;
    validM   = 1'b0;
    validS   = 1'b0;
    loadData = 8'h00;

    // Asynchronous reset asserted mid-cycle, before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst sout", {31'd0, soutL}, 32'd0);
    checkOutput("rst sout_valid", {31'd0, soutValidL}, 32'd0);
    checkOutput("rst first", {31'd0, firstL}, 32'd0);
    checkOutput("rst last", {31'd0, lastL}, 32'd0);
    checkOutput("rst busy", {31'd0, busyL}, 32'd0);
    checkOutput("rst ready", {31'd0, readyL}, 32'd1);
    checkOutput("rst msb sout_valid", {31'd0, soutValidM}, 32'd0);
    checkOutput("rst slow ready", {31'd0, readyS}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 8'hA5 on both single-clock instances: LSB first gives 1,0,1,0,0,1,0,1
    // and MSB first gives the same sequence for this palindrome-like word.
    word = 8'hA5;
    applyStimulus(1'b1, 1'b1, 1'b0, word);
    checkOutput("a5 ready", {31'd0, readyL}, 32'd1);
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput($sformatf("a5 lsb sout c%0d", c), {31'd0, soutL}, {31'd0, word[c-1]});
      checkOutput($sformatf("a5 msb sout c%0d", c), {31'd0, soutM}, {31'd0, word[8-c]});
      checkOutput($sformatf("a5 valid c%0d", c), {31'd0, soutValidL}, 32'd1);
      checkOutput($sformatf("a5 first c%0d", c), {31'd0, firstL}, {31'd0, c == 1});
      checkOutput($sformatf("a5 last c%0d", c), {31'd0, lastL}, {31'd0, c == 8});
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("a5 busy after", {31'd0, busyL}, 32'd0);
    checkOutput("a5 valid after", {31'd0, soutValidL}, 32'd0);
    checkOutput("a5 idle sout", {31'd0, soutL}, 32'd0);
    checkOutput("a5 msb busy after", {31'd0, busyM}, 32'd0);

    // MSB first with 8'h0F: 0,0,0,0,1,1,1,1.
    word = 8'h0F;
    applyStimulus(1'b0, 1'b1, 1'b0, word);
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput($sformatf("0f msb sout c%0d", c), {31'd0, soutM}, {31'd0, c >= 5});
      checkOutput($sformatf("0f msb last c%0d", c), {31'd0, lastM}, {31'd0, c == 8});
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("0f msb busy after", {31'd0, busyM}, 32'd0);

    // Four clocks per bit with 8'h81: ones on cycles 1-4 and 29-32 only,
    // ready again only on cycle 32.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h81);
    for (int c = 1; c <= 32; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput($sformatf("slow sout c%0d", c), {31'd0, soutS}, {31'd0, (c <= 4) || (c >= 29)});
      checkOutput($sformatf("slow valid c%0d", c), {31'd0, soutValidS}, 32'd1);
      checkOutput($sformatf("slow ready c%0d", c), {31'd0, readyS}, {31'd0, c == 32});
      checkOutput($sformatf("slow first c%0d", c), {31'd0, firstS}, {31'd0, c <= 4});
      checkOutput($sformatf("slow last c%0d", c), {31'd0, lastS}, {31'd0, c >= 29});
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("slow busy after", {31'd0, busyS}, 32'd0);

    // Back-to-back: 8'hFF then 8'h00 with valid held; the second word is
    // taken on cycle 8 and the line stays valid for 16 cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF);
    for (int c = 1; c <= 16; c++) begin
      applyStimulus(c <= 8, 1'b0, 1'b0, 8'h00);
      checkOutput($sformatf("b2b sout c%0d", c), {31'd0, soutL}, {31'd0, c <= 8});
      checkOutput($sformatf("b2b valid c%0d", c), {31'd0, soutValidL}, 32'd1);
      checkOutput($sformatf("b2b first c%0d", c), {31'd0, firstL}, {31'd0, (c == 1) || (c == 9)});
      checkOutput($sformatf("b2b ready c%0d", c), {31'd0, readyL}, {31'd0, (c == 8) || (c == 16)});
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("b2b busy after", {31'd0, busyL}, 32'd0);

    // Abort: 8'hC3 sends 1,1,0,0 then reset drops the word at once.
    word = 8'hC3;
    applyStimulus(1'b1, 1'b0, 1'b0, word);
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput($sformatf("c3 sout c%0d", c), {31'd0, soutL}, {31'd0, word[c-1]});
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort sout_valid", {31'd0, soutValidL}, 32'd0);
    checkOutput("abort busy", {31'd0, busyL}, 32'd0);
    checkOutput("abort sout", {31'd0, soutL}, 32'd0);
    checkOutput("abort ready", {31'd0, readyL}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 8'h3C after the abort goes out intact (0,0,1,1,1,1,0,0) while valid
    // stays high and load_data toggles during the frame.
    word = 8'h3C;
    applyStimulus(1'b1, 1'b0, 1'b0, word);
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(c <= 7, 1'b0, 1'b0, (c % 2 == 1) ? 8'hFF : 8'h55);
      checkOutput($sformatf("3c sout c%0d", c), {31'd0, soutL}, {31'd0, word[c-1]});
      checkOutput($sformatf("3c first c%0d", c), {31'd0, firstL}, {31'd0, c == 1});
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("3c busy after", {31'd0, busyL}, 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
